// File: rtl/spi_burst_master.sv
// spi_burst_master: kick-driven, chip-select-framed SPI transfer engine (CPHA=0,
// selectable CPOL). Shifts 1..DATA_WIDTH bits MSB first and returns the received
// word right-justified with a one-cycle RX_VALID strobe.
//
// Kick/busy handshake: a transfer starts when KICK is seen high in IDLE while its
// registered copy (kick_r) is low, i.e. on a rising edge only. BUSY rises the
// following cycle and stays high for exactly (2N+2)*H cycles. Kicks arriving while
// BUSY is high are ignored. RX_VALID pulses in the first IDLE cycle, which is also
// the earliest cycle a new kick edge is accepted.
module spi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        KICK,
  output logic                        BUSY,
  input  logic [DATA_WIDTH-1:0]       TX_DATA,
  input  logic [$clog2(DATA_WIDTH):0] BIT_COUNT,
  input  logic [DIV_WIDTH-1:0]        CLK_DIV,
  input  logic                        CPOL,
  output logic [DATA_WIDTH-1:0]       RX_DATA,
  output logic                        RX_VALID,
  output logic                        SPI_SCLK,
  output logic                        SPI_CS_N,
  output logic                        SPI_MOSI,
  input  logic                        SPI_MISO
);

  localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
  // Edge counter must reach 2N without wrapping.
  localparam int EDGE_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  kick_r_q, kick_r_d;
  logic [DIV_WIDTH-1:0]  hcnt_q, hcnt_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [DIV_WIDTH-1:0]  h_q, h_d;
  logic                  cpol_q, cpol_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic                  busy_q, busy_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;

  logic                  kick_start;
  logic                  half_done;
  logic [EDGE_W-1:0]     edges_total;
  logic [CNT_W-1:0]      n_eff;
  logic [DIV_WIDTH-1:0]  h_eff;
  logic [DATA_WIDTH-1:0] tx_aligned;

  // Shared decode: kick edge, half-period boundary, and the values latched at kick.
  always_comb begin
    kick_start  = (state_q == ST_IDLE) && KICK && !kick_r_q;
    half_done   = (hcnt_q == (h_q - DIV_WIDTH'(1)));
    edges_total = {n_q, 1'b0};
    n_eff       = BIT_COUNT;
    if ((BIT_COUNT == '0) || (BIT_COUNT > CNT_W'(DATA_WIDTH))) begin
      n_eff = CNT_W'(DATA_WIDTH);
    end
    h_eff = (CLK_DIV == '0) ? DIV_WIDTH'(1) : CLK_DIV;
    // Left-align the word so the current MOSI bit is always the shifter's MSB.
    tx_aligned = TX_DATA << (CNT_W'(DATA_WIDTH) - n_eff);
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      kick_r_q   <= 1'b0;
      hcnt_q     <= '0;
      edge_q     <= '0;
      n_q        <= CNT_W'(DATA_WIDTH);
      h_q        <= DIV_WIDTH'(1);
      cpol_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      busy_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      kick_r_q   <= kick_r_d;
      hcnt_q     <= hcnt_d;
      edge_q     <= edge_d;
      n_q        <= n_d;
      h_q        <= h_d;
      cpol_q     <= cpol_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      busy_q     <= busy_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Next-state decode: each phase ends on a half-period boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (kick_start) state_d = ST_SETUP;
      ST_SETUP: if (half_done) state_d = ST_SHIFT;
      ST_SHIFT: if (half_done && (edge_q == edges_total)) state_d = ST_GAP;
      ST_GAP:   if (half_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath decode: SCLK edges, MOSI shifting, MISO sampling, strobe.
  always_comb begin
    kick_r_d   = KICK;
    hcnt_d     = half_done ? '0 : (hcnt_q + DIV_WIDTH'(1));
    edge_d     = edge_q;
    n_d        = n_q;
    h_d        = h_q;
    cpol_d     = cpol_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    busy_d     = busy_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    case (state_q)
      ST_IDLE: begin
        hcnt_d = '0;
        busy_d = 1'b0;
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        sclk_d = CPOL;
        if (kick_start) begin
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          n_d     = n_eff;
          h_d     = h_eff;
          cpol_d  = CPOL;
          tx_sh_d = tx_aligned;
          mosi_d  = tx_aligned[DATA_WIDTH-1];
          rx_sh_d = '0;
          edge_d  = '0;
        end
      end

      ST_SETUP: begin
        // End of setup: first leading edge, sample the first MISO bit.
        if (half_done) begin
          sclk_d  = ~cpol_q;
          rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], SPI_MISO};
          edge_d  = EDGE_W'(1);
        end
      end

      ST_SHIFT: begin
        if (half_done) begin
          if (edge_q == edges_total) begin
            // CS hold half-period done: release chip select.
            cs_n_d = 1'b1;
            mosi_d = 1'b0;
          end else if (edge_q[0]) begin
            // Trailing edge; MOSI moves on unless this was the last bit.
            sclk_d = cpol_q;
            if (edge_q != (edges_total - EDGE_W'(1))) begin
              tx_sh_d = tx_sh_q << 1;
              mosi_d  = tx_sh_q[DATA_WIDTH-2];
            end
            edge_d = edge_q + EDGE_W'(1);
          end else begin
            // Leading edge; capture MISO as it is before SCLK changes.
            sclk_d  = ~cpol_q;
            rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], SPI_MISO};
            edge_d  = edge_q + EDGE_W'(1);
          end
        end
      end

      ST_GAP: begin
        sclk_d = cpol_q;
        if (half_done) begin
          busy_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end
      end

      default: begin
        busy_d = 1'b0;
        cs_n_d = 1'b1;
      end
    endcase
  end

  assign BUSY     = busy_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign SPI_SCLK = sclk_q;
  assign SPI_CS_N = cs_n_q;
  assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// tb_spi_burst_master: directed checks of spi_burst_master timing and data.
module tb_spi_burst_master;

  logic        clk;
  logic        rst;
  logic        kick;
  logic        busy;
  logic [31:0] tx_data;
  logic [5:0]  bit_count;
  logic [7:0]  clk_div;
  logic        cpol;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        loop_en;
  logic        miso_fix;

  int checks;
  int passes;
  int fails;

  // Per-transfer observations
  int          first_busy;
  int          busy_cnt;
  int          busy_rises;
  int          lead_cnt;
  int          spacing_bad;
  int          valid_cnt;
  int          cs_low;
  int          last_lead;
  logic [31:0] mosi_bits;
  logic [31:0] rx_cap;
  logic        prev_sclk;
  logic        prev_busy;

  assign spi_miso = loop_en ? spi_mosi : miso_fix;

  spi_burst_master #(.DATA_WIDTH(32), .DIV_WIDTH(8)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .KICK      (kick),
    .BUSY      (busy),
    .TX_DATA   (tx_data),
    .BIT_COUNT (bit_count),
    .CLK_DIV   (clk_div),
    .CPOL      (cpol),
    .RX_DATA   (rx_data),
    .RX_VALID  (rx_valid),
    .SPI_SCLK  (spi_sclk),
    .SPI_CS_N  (spi_cs_n),
    .SPI_MOSI  (spi_mosi),
    .SPI_MISO  (spi_miso)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Drives KICK (and optional extra/re-kicks) and records
  // what the SPI side does for 'window' cycles; cycle 0 is the cycle after the
  // kick-sampling clock edge.
  task automatic run_xfer(input logic [31:0] tx, input logic [5:0] bc, input logic [7:0] div,
                          input logic c, input logic loop, input int kick_len,
                          input int extra_at, input logic rekick, input int window,
                          input int spacing);
    tx_data     = tx;
    bit_count   = bc;
    clk_div     = div;
    cpol        = c;
    loop_en     = loop;
    first_busy  = -1;
    busy_cnt    = 0;
    busy_rises  = 0;
    lead_cnt    = 0;
    spacing_bad = 0;
    valid_cnt   = 0;
    cs_low      = 0;
    last_lead   = -1;
    mosi_bits   = '0;
    rx_cap      = '0;
    prev_sclk   = spi_sclk;
    prev_busy   = busy;
    kick        = 1'b1;
    for (int cyc = 0; cyc < window; cyc++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt = busy_cnt + 1;
        if (first_busy < 0) first_busy = cyc;
      end
      if (busy && !prev_busy) busy_rises = busy_rises + 1;
      if (!spi_cs_n) cs_low = cs_low + 1;
      if ((spi_sclk !== prev_sclk) && (spi_sclk !== c)) begin
        if ((last_lead >= 0) && ((cyc - last_lead) != spacing)) spacing_bad = spacing_bad + 1;
        last_lead = cyc;
        lead_cnt  = lead_cnt + 1;
        mosi_bits = {mosi_bits[30:0], spi_mosi};
      end
      if (rx_valid) begin
        valid_cnt = valid_cnt + 1;
        rx_cap    = rx_data;
      end
      prev_sclk = spi_sclk;
      prev_busy = busy;
      kick = ((cyc + 2) <= kick_len) || (cyc == extra_at) ||
             (rekick && rx_valid && (valid_cnt == 1));
    end
    kick = 1'b0;
  endtask

  initial begin
    int stray_valid;
    checks    = 0;
    passes    = 0;
    fails     = 0;
    rst       = 1'b1;
    kick      = 1'b0;
    tx_data   = '0;
    bit_count = '0;
    clk_div   = '0;
    cpol      = 1'b0;
    loop_en   = 1'b1;
    miso_fix  = 1'b0;

    // Reset for 3 cycles
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", rx_data, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // N=8, H=2, CPOL=0, 0xA5 loopback, single-cycle kick
    run_xfer(32'hA5, 6'd8, 8'd2, 1'b0, 1'b1, 1, -1, 1'b0, 40, 4);
    check("t1_latency", 32'(first_busy), 32'd0);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd36);
    check("t1_cs_low", 32'(cs_low), 32'd34);
    check("t1_leading_edges", 32'(lead_cnt), 32'd8);
    check("t1_spacing", 32'(spacing_bad), 32'd0);
    check("t1_mosi_bits", mosi_bits, 32'hA5);
    check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t1_rx_data", rx_cap, 32'h0000_00A5);
    check("t1_rx_hold", rx_data, 32'h0000_00A5);

    // BIT_COUNT=0 and CLK_DIV=0 -> full 32 bits at H=1
    run_xfer(32'hDEAD_BEEF, 6'd0, 8'd0, 1'b0, 1'b1, 1, -1, 1'b0, 70, 2);
    check("t2_busy_cycles", 32'(busy_cnt), 32'd66);
    check("t2_leading_edges", 32'(lead_cnt), 32'd32);
    check("t2_spacing", 32'(spacing_bad), 32'd0);
    check("t2_mosi_bits", mosi_bits, 32'hDEAD_BEEF);
    check("t2_rx_data", rx_cap, 32'hDEAD_BEEF);

    // CPOL=1, N=4, H=1, TX=0x9, MISO tied low
    cpol = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_idle_sclk_high", 32'(spi_sclk), 32'd1);
    miso_fix = 1'b0;
    run_xfer(32'h9, 6'd4, 8'd1, 1'b1, 1'b0, 1, -1, 1'b0, 15, 2);
    check("t3_busy_cycles", 32'(busy_cnt), 32'd10);
    check("t3_falling_leads", 32'(lead_cnt), 32'd4);
    check("t3_spacing", 32'(spacing_bad), 32'd0);
    check("t3_mosi_seq", mosi_bits, 32'h9);
    check("t3_rx_data", rx_cap, 32'h0);
    check("t3_sclk_after", 32'(spi_sclk), 32'd1);

    // KICK held high 100 cycles -> one transfer
    run_xfer(32'h3C, 6'd8, 8'd2, 1'b0, 1'b1, 100, -1, 1'b0, 110, 4);
    check("t4_busy_rises", 32'(busy_rises), 32'd1);
    check("t4_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t4_rx_data", rx_cap, 32'h3C);

    // Extra kick pulse mid-transfer is discarded
    run_xfer(32'h5A, 6'd8, 8'd2, 1'b0, 1'b1, 1, 10, 1'b0, 40, 4);
    check("t5_busy_rises", 32'(busy_rises), 32'd1);
    check("t5_busy_cycles", 32'(busy_cnt), 32'd36);
    check("t5_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t5_rx_data", rx_cap, 32'h5A);

    // Kick edge on the first IDLE cycle is accepted (back-to-back transfers)
    run_xfer(32'h6, 6'd4, 8'd1, 1'b0, 1'b1, 1, -1, 1'b1, 30, 2);
    check("t6_busy_rises", 32'(busy_rises), 32'd2);
    check("t6_busy_cycles", 32'(busy_cnt), 32'd20);
    check("t6_valid_cnt", 32'(valid_cnt), 32'd2);
    check("t6_rx_data", rx_cap, 32'h6);

    // Reset during SHIFT of an N=16 transfer
    tx_data   = 32'h0000_F00D;
    bit_count = 6'd16;
    clk_div   = 8'd1;
    cpol      = 1'b0;
    loop_en   = 1'b1;
    kick      = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    repeat (7) @(negedge clk);
    check("t7_busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t7_reset_busy", 32'(busy), 32'd0);
    check("t7_reset_cs_n", 32'(spi_cs_n), 32'd1);
    check("t7_reset_sclk", 32'(spi_sclk), 32'd0);
    check("t7_reset_mosi", 32'(spi_mosi), 32'd0);
    check("t7_reset_rx_valid", 32'(rx_valid), 32'd0);
    check("t7_reset_rx_data", rx_data, 32'd0);
    rst = 1'b0;
    stray_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_valid || busy) stray_valid = stray_valid + 1;
    end
    check("t7_no_valid_after_reset", 32'(stray_valid), 32'd0);
    run_xfer(32'h1234, 6'd16, 8'd1, 1'b0, 1'b1, 1, -1, 1'b0, 40, 2);
    check("t7_busy_cycles", 32'(busy_cnt), 32'd34);
    check("t7_leading_edges", 32'(lead_cnt), 32'd16);
    check("t7_mosi_bits", mosi_bits, 32'h1234);
    check("t7_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t7_rx_data", rx_cap, 32'h0000_1234);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_burst_master.md
Name: spi_burst_master

Overview:
- SPI transaction engine that consumes the kick pulses issued by the SPI repeater.
- Each rising edge on KICK performs one chip-select-framed transfer of 1..DATA_WIDTH bits, MSB first.
- It drives BUSY so the repeater can pace repetitions, and returns the received word with a one-cycle valid strobe.
- SPI mode: CPHA=0, CPOL selectable.

Parameters:
- DATA_WIDTH, 32: maximum bits per transfer; width of TX_DATA/RX_DATA.
- DIV_WIDTH, 8: width of CLK_DIV.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- KICK  in  1  start request; rising-edge sensitive.
- BUSY  out  1  high while a transfer (including gap) is in progress.
- TX_DATA  in  DATA_WIDTH  transmit word, right-justified; latched at kick.
- BIT_COUNT  in  $clog2(DATA_WIDTH)+1  bits per transfer N; latched at kick.
- CLK_DIV  in  DIV_WIDTH  SCLK half-period in CLK cycles; latched at kick.
- CPOL  in  1  SCLK idle level; latched at kick.
- RX_DATA  out  DATA_WIDTH  received word, right-justified, upper bits zero.
- RX_VALID  out  1  one-cycle pulse when RX_DATA updates.
- SPI_SCLK  out  1  serial clock.
- SPI_CS_N  out  1  chip select, active low.
- SPI_MOSI  out  1  serial data out.
- SPI_MISO  in  1  serial data in.

Behaviour:
- Reset: BUSY=0, RX_VALID=0, RX_DATA=0, SPI_CS_N=1, SPI_SCLK=0, SPI_MOSI=0, kick_r=0, state IDLE.
- Reset mid-transfer: all outputs return to reset values on the next cycle; no RX_VALID.
- Kick detection:
  - kick_r is a registered copy of KICK, updated every cycle in every state.
  - A kick is recognised in IDLE when KICK=1 and kick_r=0.
  - KICK held high therefore starts exactly one transfer; kicks seen while BUSY are discarded.
- Latency: BUSY=1 and SPI_CS_N=0 in the cycle after the kick is sampled (call it k=0).
  - This lets the repeater observe BUSY two cycles after asserting its kick.
- Latching at kick:
  - H = CLK_DIV, with 0 treated as 1.
  - N = BIT_COUNT, with 0 or >DATA_WIDTH treated as DATA_WIDTH.
  - CPOL is also latched; TX_DATA is loaded into the shift register.
- In IDLE, SPI_SCLK follows the registered CPOL input.
- States and timing, with k relative to BUSY rise:
  - IDLE -> SETUP on kick.
  - SETUP, k in [0,H): CS_N=0, SCLK=idle level, MOSI = TX_DATA[N-1].
  - SHIFT, k in [H,(2N+1)H): for bit i = 0..N-1:
    - leading edge (SCLK to active level) at k = H+2iH;
    - trailing edge (back to idle level) at k = H+(2i+1)H;
    - SPI_MISO is sampled into the receive shift register (shift left, insert LSB) on the CLK edge that registers the leading edge;
    - on each trailing edge except the last, MOSI advances to the next lower bit.
  - Final half-period after the last trailing edge: SCLK idle, CS_N=0 (CS hold time).
  - GAP, k in [(2N+1)H,(2N+2)H): CS_N=1, MOSI=0, SCLK idle.
  - At k=(2N+2)H: BUSY=0, RX_VALID=1 for one cycle, RX_DATA = received bits zero-extended; return to IDLE.
- BUSY is high for exactly (2N+2)H cycles.
- A kick is accepted on the first IDLE cycle (k=(2N+2)H) if the edge occurs there.
- Counters:
  - Half-period counter is DIV_WIDTH bits and reloads every H cycles.
  - Edge counter counts 2N half-periods; no wrap within a transfer.
- RX_DATA holds its value until the next completed transfer.

Test Plan:
- Reset: assert RESET 3 cycles -> BUSY=0, CS_N=1, SCLK=0, MOSI=0, RX_VALID=0, RX_DATA=0.
- N=8, CLK_DIV=2, CPOL=0, TX_DATA=0xA5, MISO looped to MOSI, 1-cycle KICK:
  - BUSY=1 exactly one cycle after KICK and high for 36 cycles;
  - 8 rising SCLK edges at 4-cycle spacing;
  - RX_VALID pulse with RX_DATA=0x000000A5.
- BIT_COUNT=0, CLK_DIV=0, TX_DATA=0xDEADBEEF, loopback:
  - 32 bits at H=1;
  - BUSY high 66 cycles;
  - RX_DATA=0xDEADBEEF.
- CPOL=1, N=4, CLK_DIV=1, TX_DATA=0x9, MISO tied 0:
  - SCLK idle high, falling leading edges;
  - MOSI sequence 1,0,0,1;
  - RX_DATA=0.
- KICK held high 100 cycles, plus an extra KICK pulse mid-transfer -> exactly one transfer and one RX_VALID.
- RESET asserted during SHIFT of an N=16 transfer -> next cycle CS_N=1, BUSY=0, no RX_VALID; a following KICK runs a full, correct transfer.
